fft_frame_sched: RTL
====================

FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 Parameters SHALL be: NBW_IN, default 9, sample width per I/Q component; FFT_SIZE, default 8, points per frame; NBW_FS, default 3, log2(FFT_SIZE); GAP, default 4, idle cycles between frames.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock, all logic on its rising edge.
- rst_async_n  in  1  asynchronous active-low reset.
- i_overlap  in  NBW_FS  requested overlap in samples.
- i_cfg_load  in  1  captures i_overlap into the shadow register.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  upstream ready.
- s_data  in  2 x NBW_IN signed  upstream sample, index 0 = I, 1 = Q.
- o_fft_valid  out  1  sample valid toward the FFT.
- o_fft_data  out  2 x NBW_IN signed  sample toward the FFT.
- o_sof  out  1  start of frame, high with the first sample of each frame.
- o_frame_id  out  8  index of the frame being emitted.
- i_fft_valid  in  1  FFT output valid.
- i_hi_lo  in  1  FFT hi/lo flag.
- o_busy  out  1  state is not IDLE.
- o_err_seq  out  1  sticky FFT output sequencing error.

Function
REQ-003 The input FIFO SHALL hold FFT_SIZE samples; s_ready = !full; a push occurs on s_valid && s_ready.
REQ-004 A simultaneous push and pop SHALL leave the FIFO count unchanged, and a push when full SHALL NOT occur.
REQ-005 When i_cfg_load = 1, the shadow overlap SHALL take min(i_overlap, FFT_SIZE/2).
REQ-006 The active overlap OV SHALL latch from the shadow register only on the IDLE exit, and SHALL stay constant for the whole frame.
REQ-007 States SHALL be IDLE, REPLAY, FILL and DRAIN, with these transitions:
- IDLE to REPLAY, or to FILL when OV = 0, once the FIFO count is at least FFT_SIZE-OV.
- REPLAY to FILL after OV cycles.
- FILL to DRAIN after FFT_SIZE-OV cycles.
- DRAIN to IDLE after GAP cycles.
REQ-008 REPLAY SHALL emit one history sample per cycle, oldest first (hist[OV-1] down to hist[0]).
REQ-009 FILL SHALL pop one FIFO sample per cycle and emit it.
REQ-010 Every emitted sample SHALL shift into the history shift register of depth FFT_SIZE/2, with hist[0] holding the newest sample.
REQ-011 Each frame SHALL be exactly FFT_SIZE contiguous o_fft_valid cycles.
REQ-012 Because the FIFO pre-check guarantees data, FILL SHALL never stall.
REQ-013 o_fft_valid, o_fft_data and o_sof SHALL be registered, one cycle after the REPLAY/FILL state cycle that produces them.
REQ-014 o_fft_data SHALL hold its last value when o_fft_valid = 0.
REQ-015 o_frame_id SHALL increment on the last sample of each frame and wrap from 255 to 0.
REQ-016 The monitor SHALL count consecutive i_fft_valid cycles in each burst and expect:
- i_hi_lo = 0 for the first FFT_SIZE/2 cycles;
- i_hi_lo = 1 for the next FFT_SIZE/2 cycles.
REQ-017 o_err_seq SHALL set and stay high on any of:
- an i_hi_lo mismatch;
- a burst that is not exactly FFT_SIZE cycles long;
- i_fft_valid high in REPLAY or FILL while a previous burst has not ended.
REQ-018 o_busy SHALL be 1 in REPLAY, FILL and DRAIN.
REQ-019 A frame with OV = 0 SHALL contain no history samples, and its history SHALL still update.

Reset
REQ-020 While rst_async_n = 0, all of the following SHALL be held: state IDLE; FIFO empty; s_ready 0; history all zero; shadow overlap and OV 0; o_fft_valid 0; o_sof 0; o_fft_data 0; o_frame_id 0; o_busy 0; o_err_seq 0; monitor counter 0.
REQ-021 s_ready SHALL rise on the first clk edge after deassertion.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately with no further o_fft_valid.
REQ-023 The first frame after reset SHALL replay zeros as history when OV > 0.

Verification
REQ-024 Reset, OV 0, push samples 1..8 back to back -> from the cycle after state enters FILL: 8 consecutive o_fft_valid with data 1..8, o_sof on the 1, o_frame_id 0 then 1, then 4 idle cycles.
REQ-025 Load overlap 2, push 1..8 then 9..14 -> frame 1 data is 7,8,9..14, OV latched at 2.
REQ-026 Load overlap 7 -> clamped to 4; frame 1 replays samples 5,6,7,8.
REQ-027 Upstream pushes with a gap mid-frame (s_valid low 3 cycles) -> no frame starts until FIFO count >= FFT_SIZE-OV, and the emitted burst has no holes.
REQ-028 FIFO full, s_valid held high -> s_ready 0 and no sample lost; same-cycle push and pop keeps the count.
REQ-029 Drive i_fft_valid for 8 cycles with i_hi_lo 0,0,0,0,1,1,1,1 -> o_err_seq stays 0; with a 1 in slot 2, or a 7-cycle burst -> o_err_seq = 1 until reset.
REQ-030 Assert reset during REPLAY -> o_fft_valid 0 on the same cycle, FIFO empty and history zero after release.

Source files
------------

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: input FIFO plus overlap-replay frame scheduler feeding an
// FFT, with a sequence monitor on the FFT output side.
//   clk, rst_async_n     : clock (rising edge) and asynchronous active-low reset
//   i_overlap/i_cfg_load : overlap request, captured (clamped) into a shadow reg
//   s_valid/s_ready/s_data : upstream sample stream, s_data[0]=I, s_data[1]=Q
//   o_fft_valid/o_fft_data/o_sof/o_frame_id : registered frame stream to the FFT
//   i_fft_valid/i_hi_lo  : FFT output handshake watched by the monitor
//   o_busy/o_err_seq     : scheduler not idle / sticky output sequencing error
// Each frame is OV replayed history samples followed by FFT_SIZE-OV fresh
// samples, emitted on contiguous cycles, then GAP idle cycles.
// FFT_SIZE must equal 2**NBW_FS (FIFO pointers wrap naturally).
module fft_frame_sched #(
  parameter int NBW_IN   = 9,
  parameter int FFT_SIZE = 8,
  parameter int NBW_FS   = 3,
  parameter int GAP      = 4
) (
  input  logic                     clk,
  input  logic                     rst_async_n,
  input  logic [NBW_FS-1:0]        i_overlap,
  input  logic                     i_cfg_load,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [1:0][NBW_IN-1:0]   s_data,
  output logic                     o_fft_valid,
  output logic [1:0][NBW_IN-1:0]   o_fft_data,
  output logic                     o_sof,
  output logic [7:0]               o_frame_id,
  input  logic                     i_fft_valid,
  input  logic                     i_hi_lo,
  output logic                     o_busy,
  output logic                     o_err_seq
);

  localparam int HALF = FFT_SIZE / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CNTW = NBW_FS + 1;
  // Phase counter must reach both FFT_SIZE-1 and GAP-1.
  localparam int CW   = (NBW_FS + 1 > $clog2(GAP) + 1) ? NBW_FS + 1 : $clog2(GAP) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REPLAY = 2'd1;
  localparam logic [1:0] ST_FILL   = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]                     state;
  logic [CW-1:0]                  cnt;
  logic [NBW_FS-1:0]              shadow_ov;
  logic [NBW_FS-1:0]              ov;

  // ---------------------------------------------------------------- input FIFO
  logic [1:0][NBW_IN-1:0]         mem [FFT_SIZE];
  logic [NBW_FS-1:0]              wr_ptr;
  logic [NBW_FS-1:0]              rd_ptr;
  logic [CNTW-1:0]                count;
  logic                           rdy_en;
  logic                           push;
  logic                           pop;

  // rdy_en keeps s_ready low through reset and raises it on the first edge after.
  assign s_ready = rdy_en && (count != CNTW'(FFT_SIZE));
  assign push    = s_valid && s_ready;
  // FILL is only entered once enough samples are buffered, so it pops blindly.
  assign pop     = (state == ST_FILL);

  // Storage needs no reset: the count defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ overlap config
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      shadow_ov <= '0;
    end else if (i_cfg_load) begin
      shadow_ov <= (i_overlap > NBW_FS'(HALF)) ? NBW_FS'(HALF) : i_overlap;
    end
  end

  // ------------------------------------------------------------ frame FSM
  logic [CNTW-1:0] start_thr;
  assign start_thr = CNTW'(FFT_SIZE) - CNTW'(shadow_ov);

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ov    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The shadow value is the one that will become OV, so it sets the
          // fill threshold; OV then stays frozen for the frame.
          if (count >= start_thr) begin
            ov    <= shadow_ov;
            cnt   <= '0;
            state <= (shadow_ov == '0) ? ST_FILL : ST_REPLAY;
          end
        end
        ST_REPLAY: begin
          // cnt keeps running into FILL: it is the sample position in the frame.
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ov) - CW'(1)) begin
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (cnt == CW'(FFT_SIZE - 1)) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CW'(GAP - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE);

  // ------------------------------------------------------- history + output
  logic [HALF-1:0][1:0][NBW_IN-1:0] hist;
  logic [HW-1:0]                    hist_idx;
  logic                             emit;
  logic [1:0][NBW_IN-1:0]           emit_dat;
  logic                             last_q;

  // Replayed samples are shifted back into the history as they go out, so the
  // oldest sample still to replay always sits at hist[OV-1]; after OV cycles
  // the history holds the same OV samples again, in the same order.
  assign hist_idx = HW'(ov - 1'b1);
  assign emit     = (state == ST_REPLAY) || (state == ST_FILL);
  assign emit_dat = (state == ST_REPLAY) ? hist[hist_idx] : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      hist        <= '0;
      o_fft_valid <= 1'b0;
      o_fft_data  <= '0;
      o_sof       <= 1'b0;
      last_q      <= 1'b0;
      o_frame_id  <= '0;
    end else begin
      o_fft_valid <= emit;
      o_sof       <= emit && (cnt == '0);
      last_q      <= (state == ST_FILL) && (cnt == CW'(FFT_SIZE - 1));
      if (emit) begin
        o_fft_data <= emit_dat;
        hist       <= {hist[HALF-2:0], emit_dat};
      end
      // Advance once the last sample of the frame has been presented, so the
      // id is stable across every sample of its own frame.
      if (last_q) begin
        o_frame_id <= o_frame_id + 8'd1;
      end
    end
  end

  // ---------------------------------------------------- FFT output monitor
  logic [CNTW-1:0] mon_cnt;
  logic            exp_hi;

  assign exp_hi = (mon_cnt >= CNTW'(HALF));

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      mon_cnt   <= '0;
      o_err_seq <= 1'b0;
    end else begin
      if (i_fft_valid) begin
        if (mon_cnt == CNTW'(FFT_SIZE)) begin
          // Valid still high after a full burst: the burst overran, or a new
          // one started before the previous one ended.
          o_err_seq <= 1'b1;
        end else begin
          if (i_hi_lo != exp_hi) begin
            o_err_seq <= 1'b1;
          end
          mon_cnt <= mon_cnt + 1'b1;
        end
      end else begin
        if ((mon_cnt != '0) && (mon_cnt != CNTW'(FFT_SIZE))) begin
          o_err_seq <= 1'b1;
        end
        mon_cnt <= '0;
      end
    end
  end

endmodule
